n1_pbus_tgt: RTL
================

Name: n1_pbus_tgt

Overview:
Read-only Wishbone pipelined target for the N1 program bus. It is the responder to the flow-control initiator's pbus_cyc/stb/ack/err/stall handshake. It turns accepted fetch requests into reads on a fixed-latency synchronous memory port and returns ACK or ERR strictly in order. It also bounds the number of outstanding requests and flushes in-flight responses when the initiator drops CYC.

Parameters:
PBUS_AW, 14, program bus word-address width
PBUS_DW, 16, data width
MEM_SIZE, 12288, implemented words; addresses >= MEM_SIZE return ERR
RD_LAT, 1, memory read latency in cycles (legal 1..4)
MAX_OUTST, 2, max accepted-but-unanswered requests (legal 1..RD_LAT+1)

Ports:
clk_i  in  1  module clock
async_rst_i  in  1  asynchronous reset, active-low
pbus_cyc_i  in  1  bus cycle indicator
pbus_stb_i  in  1  access request
pbus_adr_i  in  PBUS_AW  word address
pbus_ack_o  out  1  bus acknowledge, data valid
pbus_err_o  out  1  error indicator (address out of range)
pbus_stall_o  out  1  access delay
pbus_dat_o  out  PBUS_DW  read data
mem_re_o  out  1  memory read strobe
mem_adr_o  out  PBUS_AW  memory address
mem_dat_i  in  PBUS_DW  memory data, valid RD_LAT cycles after mem_re_o
prb_pbus_tgt_state_o  out  1  probe: 0=IDLE, 1=BUSY
prb_pbus_tgt_outst_o  out  3  probe: outstanding count

Behaviour:
- Clock clk_i; single reset async_rst_i, asynchronous, active-low. No synchronous reset.
- Reset values: pbus_ack_o=0, pbus_err_o=0, pbus_dat_o=0, pbus_stall_o=0, outstanding count=0, all pipeline valid bits=0, state IDLE.
- Accept = pbus_cyc_i & pbus_stb_i & ~pbus_stall_o.
- Accept with adr < MEM_SIZE: combinationally assert mem_re_o=1 with mem_adr_o=pbus_adr_i in the same cycle.
- Accept with adr >= MEM_SIZE: mem_re_o=0; the pipeline entry is tagged err.
- mem_adr_o = pbus_adr_i at all times; mem_re_o=0 when not accepting.
- Latency pipeline: RD_LAT stages of {valid, err}, shifted every cycle.
  - Stage RD_LAT valid coincides with valid mem_dat_i.
  - In that cycle, registered outputs load: ack=~err, err=err, dat=err?0:mem_dat_i.
  - Result: response appears exactly RD_LAT+1 cycles after accept.
  - Out-of-range requests take the same latency, which keeps ordering.
- pbus_ack_o and pbus_err_o are single-cycle pulses and mutually exclusive. pbus_dat_o=0 in any cycle without ack.
- Outstanding count:
  - +1 on accept, -1 on ack|err; simultaneous accept and response leaves it unchanged.
  - Never exceeds MAX_OUTST; never underflows (assert).
- pbus_stall_o = (count == MAX_OUTST), combinational from the count register only (no input-to-stall path).
- Abort: pbus_cyc_i=0 in any cycle clears all pipeline valid bits and the count at the next edge.
  - A response already registered for that cycle is still driven; no further responses are issued.
  - Memory data returning afterwards is discarded.
  - A new cycle may start in the cycle after the abort.
- pbus_stb_i while pbus_cyc_i=0 is ignored.
- FSM: IDLE (count==0) -> BUSY on accept; BUSY -> IDLE when count reaches 0 or on abort.
- Reset mid-operation: all outputs go to reset values immediately; in-flight requests are lost.

Decomposition:
- Shared package n1_pbus_pkg: PBUS address/data width constants, state encoding (IDLE/BUSY), outstanding-count width function clog2(MAX_OUTST+1).
- Sub-module n1_pbus_tgt_pipe: RD_LAT-deep {valid,err} shift register with flush input. Used for the latency pipeline; the top holds accept logic, counter, output registers and FSM.

Test Plan:
1. Single read, RD_LAT=1, adr=0x0010 at cycle 0 -> mem_re_o=1, mem_adr_o=0x0010 at cycle 0; model drives mem_dat_i=0xA5A5 at cycle 1 -> ack=1, dat=0xA5A5 at cycle 2; err=0; count back to 0 at cycle 3.
2. Back-to-back stb for adr 0x0001..0x0004, RD_LAT=1, MAX_OUTST=2 -> stall=1 after the 2nd accept; throughput one accept per response; four acks in address order with matching data; never more than 2 outstanding.
3. Out-of-range: adr=0x3000 (MEM_SIZE=12288) -> mem_re_o=0; err=1, ack=0, dat=0x0000 at accept+2.
4. Mixed stream 0x0005, 0x3001, 0x0006, RD_LAT=2, MAX_OUTST=3 -> responses ack, err, ack in order at accept+3 each; data matches addresses 5 and 6.
5. Abort: two requests accepted, cyc dropped the next cycle with RD_LAT=2 -> no ack/err afterwards, count=0, stall=0; a new request then completes normally.
6. Reset asserted (async_rst_i=0) while 2 requests are outstanding -> ack/err/stall/dat go to 0 without a clock edge; after release, state=IDLE and count=0.

Source files
------------

// File: rtl/n1_pbus_pkg.sv
// Shared widths, state encoding and sizing helper for the N1 program-bus target.
package n1_pbus_pkg;

   localparam int PBUS_AW_DEF = 14;
   localparam int PBUS_DW_DEF = 16;
   localparam int PRB_OUTST_W = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } tgt_state_e;

   function automatic int outst_w(input int max_outst);
      return $clog2(max_outst + 1);
   endfunction

endpackage

// File: rtl/n1_pbus_tgt_pipe.sv
// Fixed-latency {valid, err} shift register that tracks fetches in flight to memory.
module n1_pbus_tgt_pipe
   import n1_pbus_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flush,
   input  logic push_valid,
   input  logic push_err,
   output logic pop_valid,
   output logic pop_err
);

   logic [RD_LAT-1:0] valid_r;
   logic [RD_LAT-1:0] err_r;

   // Shift one stage per cycle; an aborted bus cycle drops everything in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= '0;
         err_r   <= '0;
      end else if (flush) begin
         valid_r <= '0;
         err_r   <= '0;
      end else begin
         valid_r[0] <= push_valid;
         err_r[0]   <= push_err;
         for (int i = 1; i < RD_LAT; i++) begin
            valid_r[i] <= valid_r[i-1];
            err_r[i]   <= err_r[i-1];
         end
      end
   end

   assign pop_valid = valid_r[RD_LAT-1];
   assign pop_err   = err_r[RD_LAT-1];

endmodule

// File: rtl/n1_pbus_tgt.sv
// Read-only pipelined Wishbone target: turns accepted fetches into fixed-latency
// memory reads and returns ACK/ERR in order, with a bounded number in flight.
module n1_pbus_tgt
   import n1_pbus_pkg::*;
#(
   parameter int PBUS_AW   = PBUS_AW_DEF,
   parameter int PBUS_DW   = PBUS_DW_DEF,
   parameter int MEM_SIZE  = 12288,
   parameter int RD_LAT    = 1,
   parameter int MAX_OUTST = 2
) (
   input  logic               clk_i,
   input  logic               async_rst_i,
   input  logic               pbus_cyc_i,
   input  logic               pbus_stb_i,
   input  logic [PBUS_AW-1:0] pbus_adr_i,
   output logic               pbus_ack_o,
   output logic               pbus_err_o,
   output logic               pbus_stall_o,
   output logic [PBUS_DW-1:0] pbus_dat_o,
   output logic               mem_re_o,
   output logic [PBUS_AW-1:0] mem_adr_o,
   input  logic [PBUS_DW-1:0] mem_dat_i,
   output logic               prb_pbus_tgt_state_o,
   output logic [2:0]         prb_pbus_tgt_outst_o
);

   localparam int                CW        = outst_w(MAX_OUTST);
   localparam logic [PBUS_AW:0]  MEM_LIM   = (PBUS_AW+1)'(MEM_SIZE);
   localparam logic [CW-1:0]     OUTST_MAX = CW'(MAX_OUTST);

   tgt_state_e         state_r, state_nxt_s;
   logic [CW-1:0]      outst_r, outst_nxt_s;
   logic               ack_r, err_r;
   logic [PBUS_DW-1:0] dat_r;
   logic               stall_s, accept_s, in_range_s, rsp_done_s;
   logic               pipe_valid_s, pipe_err_s, rsp_valid_s;

   // Stall depends on the count register only, so no input reaches it combinationally
   assign stall_s     = (outst_r == OUTST_MAX);
   assign accept_s    = pbus_cyc_i & pbus_stb_i & ~stall_s;
   assign in_range_s  = ({1'b0, pbus_adr_i} < MEM_LIM);
   assign rsp_done_s  = ack_r | err_r;
   assign rsp_valid_s = pipe_valid_s & pbus_cyc_i;

   assign mem_re_o  = accept_s & in_range_s;
   assign mem_adr_o = pbus_adr_i;

   n1_pbus_tgt_pipe #(
      .RD_LAT (RD_LAT)
   ) u_pipe (
      .clk        (clk_i),
      .rst_n      (async_rst_i),
      .flush      (~pbus_cyc_i),
      .push_valid (accept_s),
      .push_err   (~in_range_s),
      .pop_valid  (pipe_valid_s),
      .pop_err    (pipe_err_s)
   );

   // Next outstanding count and FSM state
   always_comb begin
      outst_nxt_s = outst_r;
      state_nxt_s = state_r;
      if (!pbus_cyc_i) begin
         outst_nxt_s = {CW{1'b0}};
      end else begin
         case ({accept_s, rsp_done_s})
            2'b10:   outst_nxt_s = outst_r + CW'(1);
            2'b01:   outst_nxt_s = outst_r - CW'(1);
            default: outst_nxt_s = outst_r;
         endcase
      end
      case (state_r)
         ST_IDLE: begin
            if (accept_s) state_nxt_s = ST_BUSY;
            else          state_nxt_s = ST_IDLE;
         end
         ST_BUSY: begin
            if (!pbus_cyc_i || (outst_nxt_s == {CW{1'b0}})) state_nxt_s = ST_IDLE;
            else                                            state_nxt_s = ST_BUSY;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State, count and registered bus response
   always_ff @(posedge clk_i or negedge async_rst_i) begin
      if (!async_rst_i) begin
         state_r <= ST_IDLE;
         outst_r <= {CW{1'b0}};
         ack_r   <= 1'b0;
         err_r   <= 1'b0;
         dat_r   <= {PBUS_DW{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         outst_r <= outst_nxt_s;
         ack_r   <= rsp_valid_s & ~pipe_err_s;
         err_r   <= rsp_valid_s & pipe_err_s;
         dat_r   <= (rsp_valid_s & ~pipe_err_s) ? mem_dat_i : {PBUS_DW{1'b0}};
      end
   end

   assign pbus_ack_o           = ack_r;
   assign pbus_err_o           = err_r;
   assign pbus_dat_o           = dat_r;
   assign pbus_stall_o         = stall_s;
   assign prb_pbus_tgt_state_o = state_r;
   assign prb_pbus_tgt_outst_o = PRB_OUTST_W'(outst_r);

endmodule
